lsu_initiator: RTL

LSU_INITIATOR -- requirements
Module: lsu_initiator

---
 rtl/lsu_initiator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_initiator.sv
// -----------------------------------------------------------------------------
// lsu_initiator
//
// Purpose:
//   Load/store initiator that sits between a pipeline and a single-ported data
//   memory. It accepts one access at a time and registers it. It drives lane
//   enables and a single write strobe for the memory access, waits MEM_LAT
//   cycles, and then returns one response cycle carrying the extended load
//   result and an exception code. The pipeline is stalled (pause) while an
//   access is in flight.
//
// Parameters:
//   MEM_LAT     data-memory access cycles per request (1..15)
//   ADDR_LIMIT  highest legal byte address (used only with alignment checks)
//
// Configuration macro:
//   LSU_ALIGN_CHECK_EN  when defined, misaligned or out-of-range accesses raise
//                       AdEL (4, loads) or AdES (5, stores) and skip memory.
//                       When undefined, rsp_exc is constant 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   req_valid    in   access request strobe
//   req_ready    out  request can be accepted (IDLE only)
//   req_op       in   0 LW,1 LH,2 LHU,3 LB,4 LBU,5 SW,6 SH,7 SB
//   req_addr     in   byte address
//   req_wdata    in   store data, right-justified
//   req_pc       in   PC of the access
//   mem_adr      out  registered address to memory
//   mem_write    out  registered store data (unshifted)
//   mem_pc       out  registered PC
//   byteen       out  memory lane enables
//   memw_enable  out  write strobe (one cycle per store)
//   mem_read     in   memory read data, right-justified
//   rsp_valid    out  response strobe (DONE)
//   rsp_data     out  extended load result (0 for stores/exceptions)
//   rsp_exc      out  exception code (0 none, 4 AdEL, 5 AdES)
//   pause        out  upstream stall request
// -----------------------------------------------------------------------------
module lsu_initiator #(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_write,
    output logic [31:0] mem_pc,
    output logic [3:0]  byteen,
    output logic        memw_enable,
    input  logic [31:0] mem_read,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_exc,
    output logic        pause
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [31:0] r_rsp_data;

    logic        w_accept;
    logic        w_r_is_store;
    logic        w_in_access;
    logic [3:0]  w_lanes;
    logic [31:0] w_load_data;
    logic [4:0]  w_exc;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_r_is_store = (r_op == OP_SW) || (r_op == OP_SH) || (r_op == OP_SB);
    assign w_in_access  = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Lane enables from the registered access; word/half lanes only look at
    // the address bits that select a lane group, so stray low bits are ignored.
    always_comb begin
        w_lanes = 4'b0000;
        case (r_op)
            OP_LW, OP_SW:          w_lanes = 4'b1111;
            OP_LH, OP_LHU, OP_SH:  w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
            default:               w_lanes = 4'b0001 << r_addr[1:0];
        endcase
    end

    // Memory returns the selected lanes right-justified, so extension always
    // works from bit 0 regardless of the byte offset.
    always_comb begin
        w_load_data = 32'd0;
        case (r_op)
            OP_LW:   w_load_data = mem_read;
            OP_LH:   w_load_data = {{16{mem_read[15]}}, mem_read[15:0]};
            OP_LHU:  w_load_data = {16'd0, mem_read[15:0]};
            OP_LB:   w_load_data = {{24{mem_read[7]}}, mem_read[7:0]};
            OP_LBU:  w_load_data = {24'd0, mem_read[7:0]};
            default: w_load_data = 32'd0;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic       w_req_is_store;
    logic       w_misaligned;
    logic [4:0] r_exc;

    assign w_req_is_store = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);

    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          w_misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  w_misaligned = req_addr[0];
            default:               w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_exc = EXC_NONE;
        if (w_misaligned || (req_addr > ADDR_LIMIT)) begin
            w_exc = w_req_is_store ? EXC_ADES : EXC_ADEL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exc <= EXC_NONE;
        end else if (w_accept) begin
            r_exc <= w_exc;
        end
    end

    assign rsp_exc = r_exc;
`else
    // The limit only matters to the address checks; keep it referenced so the
    // parameter list stays identical in both builds.
    logic w_unused_limit;
    assign w_unused_limit = |ADDR_LIMIT;

    assign w_exc   = EXC_NONE;
    assign rsp_exc = EXC_NONE;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op       <= OP_LW;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_pc       <= 32'd0;
            r_rsp_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= req_op;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_pc       <= req_pc;
                        r_rsp_data <= 32'd0;
                        // A faulting access never touches memory.
                        r_state    <= (w_exc != EXC_NONE) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (MEM_LAT <= 1) begin
                        r_rsp_data <= w_load_data;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt   <= 4'(MEM_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt      <= 4'd0;
                        r_rsp_data <= w_load_data;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign pause       = (r_state != S_IDLE);
    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_data    = r_rsp_data;
    assign mem_adr     = r_addr;
    assign mem_write   = r_wdata;
    assign mem_pc      = r_pc;
    assign byteen      = w_in_access ? w_lanes : 4'b0000;
    // Gated by reset directly so a store caught by reset never strobes memory.
    assign memw_enable = reset && (r_state == S_ISSUE) && w_r_is_store;

endmodule
